// File: rtl/cam_lookup_unit.sv
// cam_lookup_unit: 8-entry CAM with registered 1-cycle search and an optional saturating hit counter (CAM_HIT_COUNTER_EN)
module cam_lookup_unit #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  write_en,
  input  logic [2:0]            write_index,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  invalidate_en,
  input  logic [2:0]            invalidate_index,
  input  logic                  search_en,
  input  logic [DATA_WIDTH-1:0] search_data,
  output logic                  search_valid,
  output logic [7:0]            match_lines,
  output logic                  search_hit,
  output logic [2:0]            search_index,
  output logic                  multi_hit,
  output logic [7:0]            valid_lines,
  output logic [15:0]           hit_count
);
  logic [DATA_WIDTH-1:0] tags [8];
  logic [7:0] valid_q;
  logic [7:0] match_d;
  logic [2:0] index_d;
  logic hit_d;
  logic multi_d;
  always_comb begin
    match_d = '0;
    for (int i = 0; i < 8; i++) match_d[i] = valid_q[i] && (tags[i] == search_data);
  end
  always_comb begin
    index_d = '0;
    for (int i = 7; i >= 0; i--) index_d = match_d[i] ? 3'(i) : index_d;
  end
  assign hit_d = |match_d;
  assign multi_d = |(match_d & (match_d - 8'd1));
  assign valid_lines = valid_q;
  always_ff @(posedge clk)
    if (reset_n && write_en) tags[write_index] <= write_data;
  always_ff @(posedge clk) begin
    if (!reset_n) valid_q <= '0;
    else begin
      if (write_en) valid_q[write_index] <= 1'b1;
      if (invalidate_en) valid_q[invalidate_index] <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      search_valid <= 1'b0;
      match_lines  <= '0;
      search_hit   <= 1'b0;
      search_index <= '0;
      multi_hit    <= 1'b0;
    end else begin
      search_valid <= search_en;
      if (search_en) begin
        match_lines  <= match_d;
        search_hit   <= hit_d;
        search_index <= index_d;
        multi_hit    <= multi_d;
      end
    end
  end
`ifdef CAM_HIT_COUNTER_EN
  logic [15:0] hit_q;
  always_ff @(posedge clk) begin
    if (!reset_n) hit_q <= '0;
    else if (search_en && hit_d && hit_q != 16'hFFFF) hit_q <= hit_q + 16'd1;
  end
  assign hit_count = hit_q;
`else
  assign hit_count = '0;
`endif
endmodule
